// File: rtl/tdm_pkg.sv
// Shared types for the 4-slot TDM receive path: lane count, slot index and
// the frame-capture FSM state.
package tdm_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_t;

  // Slot that follows s within a frame; wraps to 0 after the last lane.
  function automatic slot_t next_slot(input slot_t s);
    return (s == slot_t'(LANES - 1)) ? slot_t'(0) : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_demux4_demux4.sv
// Slot-to-lane decoder: turns the current slot index into a one-hot lane
// write enable, the inverse of the transmit-side mux4 selection.
module demux4
  import tdm_pkg::*;
(
  input  slot_t             sel,
  input  logic              en,
  output logic [LANES-1:0]  lane_en
);

  always_comb begin
    lane_en = '0;
    if (en) begin
      lane_en[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM link: collects four serial slots into a frame,
// aligned by frame_start, and presents it on a valid/ready output port.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_start,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sync_err,
  output logic                   overrun
);

  tdm_state_t state, state_nxt;
  slot_t      slot, slot_nxt;
  slot_t      wr_sel;
  logic       wr_en;
  logic       sync_nxt;
  logic       complete;

  logic [LANES-1:0]       lane_en;
  logic [WIDTH-1:0]       cap [LANES];
  logic [LANES*WIDTH-1:0] frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // A frame_start always wins: in COLLECT it abandons the partial frame and
  // restarts at lane0 rather than being captured as data.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_sel    = slot;
    wr_en     = 1'b0;
    sync_nxt  = 1'b0;
    complete  = 1'b0;
    if (din_valid) begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            wr_sel    = '0;
            wr_en     = 1'b1;
            slot_nxt  = slot_t'(1);
            state_nxt = COLLECT;
          end else begin
            sync_nxt = 1'b1;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            sync_nxt  = 1'b1;
            wr_sel    = '0;
            wr_en     = 1'b1;
            slot_nxt  = slot_t'(1);
            state_nxt = COLLECT;
          end else begin
            wr_en    = 1'b1;
            slot_nxt = next_slot(slot);
            if (slot == slot_t'(LANES - 1)) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  demux4 u_demux4 (
    .sel     (wr_sel),
    .en      (wr_en),
    .lane_en (lane_en)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst) begin
        cap[i] <= '0;
      end else if (lane_en[i]) begin
        cap[i] <= din;
      end
    end
  end

  // The last lane is taken straight from din so the frame is ready on the
  // same edge that samples it.
  always_comb begin
    frame = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      frame[i*WIDTH +: WIDTH] = cap[i];
    end
    frame[(LANES-1)*WIDTH +: WIDTH] = din;
  end

  // Output handshake: a frame transfers on every rising edge where
  // out_valid && out_ready; while out_valid is high and out_ready low, dout
  // and out_valid hold, and a frame completing then is dropped (overrun).
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_err <= sync_nxt;
      overrun  <= 1'b0;
      if (complete) begin
        if (!out_valid || out_ready) begin
          dout      <= frame;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed per-cycle vector table, then random traffic
// against a slot-queue reference model with a frame scoreboard.
module tb_tdm_demux4;

  localparam int W  = 1;
  localparam int DW = 4 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          frame_start;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          sync_err;
  logic          overrun;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sync_err    (sync_err),
    .overrun     (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          dv;
    logic          fs;
    logic [W-1:0]  din;
    logic          rdy;
    logic          ov;
    logic [DW-1:0] dout;
    logic          se;
    logic          ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic dv, input logic fs, input logic d, input logic rdy,
                     input logic ov, input logic [DW-1:0] dt, input logic se, input logic ovr);
    vec_t v;
    v.rst = r; v.dv = dv; v.fs = fs; v.din = W'(d); v.rdy = rdy;
    v.ov = ov; v.dout = dt; v.se = se; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0]  cur_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_valid;
  logic [DW-1:0] m_dout;
  logic          m_se;
  logic          m_ovr;

  task automatic model_step();
    logic          done;
    logic          consumed;
    logic [DW-1:0] f;
    done = 1'b0;
    f    = '0;
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
      m_valid = 1'b0; m_dout = '0; m_se = 1'b0; m_ovr = 1'b0;
      return;
    end
    m_se     = 1'b0;
    m_ovr    = 1'b0;
    consumed = m_valid && out_ready;
    if (consumed) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_accept: DUT handshake with no frame expected, dout %h", dout);
      end else begin
        check("sb_accept_dout", dout, exp_q.pop_front());
      end
    end
    if (din_valid) begin
      if (frame_start) begin
        m_se = (cur_q.size() != 0);
        cur_q.delete();
        cur_q.push_back(din);
      end else if (cur_q.size() == 0) begin
        m_se = 1'b1;
      end else begin
        cur_q.push_back(din);
        if (cur_q.size() == 4) begin
          for (int i = 0; i < 4; i++) f[i*W +: W] = cur_q[i];
          cur_q.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        m_dout  = f;
        exp_q.push_back(f);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (consumed) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;

    //   rst dv fs d rdy | ov dout  se ovr
    add(1, 0, 0, 0, 0,   0, 4'h0, 0, 0);   // reset
    add(0, 0, 0, 0, 0,   0, 4'h0, 0, 0);
    // basic frame 1,0,1,1
    add(0, 1, 1, 1, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 1, 0,   1, 4'hD, 0, 0);
    add(0, 0, 0, 0, 1,   0, 4'hD, 0, 0);
    // gapped frame
    add(0, 1, 1, 1, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'hD, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'hD, 0, 0);
    add(0, 0, 1, 0, 0,   0, 4'hD, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 1, 0,   1, 4'hD, 0, 0);
    add(0, 0, 0, 0, 1,   0, 4'hD, 0, 0);
    // early restart on 3rd slot, then frame 5
    add(0, 1, 1, 0, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'hD, 0, 0);
    add(0, 1, 1, 1, 0,   0, 4'hD, 1, 0);
    add(0, 1, 0, 0, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'hD, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h5, 0, 0);
    add(0, 0, 0, 0, 1,   0, 4'h5, 0, 0);
    // overrun: A then B with out_ready low
    add(0, 1, 1, 0, 0,   0, 4'h5, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'h5, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h5, 0, 0);
    add(0, 1, 0, 1, 0,   1, 4'hA, 0, 0);
    add(0, 1, 1, 1, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 1, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'hA, 0, 1);
    add(0, 0, 0, 0, 0,   1, 4'hA, 0, 0);
    // concurrent accept: B completes while A is taken
    add(0, 1, 1, 1, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 1, 0,   1, 4'hA, 0, 0);
    add(0, 1, 0, 0, 1,   1, 4'h5, 0, 0);
    add(0, 0, 0, 0, 1,   0, 4'h5, 0, 0);
    // reset mid-frame, then clean frame 3
    add(0, 1, 1, 1, 0,   0, 4'h5, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'h5, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'h0, 0, 0);
    add(0, 1, 1, 1, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h3, 0, 0);
    add(0, 0, 0, 0, 1,   0, 4'h3, 0, 0);
    // stray slot in IDLE
    add(0, 1, 0, 1, 0,   0, 4'h3, 1, 0);
    add(0, 0, 0, 0, 0,   0, 4'h3, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; din_valid = vecs[i].dv; frame_start = vecs[i].fs;
      din = vecs[i].din; out_ready = vecs[i].rdy;
      cycle();
      check($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].ov));
      check($sformatf("v%0d_dout", i),      dout,           vecs[i].dout);
      check($sformatf("v%0d_sync_err", i),  DW'(sync_err),  DW'(vecs[i].se));
      check($sformatf("v%0d_overrun", i),   DW'(overrun),   DW'(vecs[i].ovr));
    end

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = (c == 0) || ($urandom_range(0, 249) == 0);
      din_valid   = ($urandom_range(0, 3) != 0);
      din         = W'($urandom);
      out_ready   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) frame_start = ($urandom_range(0, 1) == 1);
      else                            frame_start = (cur_q.size() == 0);
      model_step();
      cycle();
      check("rnd_out_valid", DW'(out_valid), DW'(m_valid));
      check("rnd_dout",      dout,           m_dout);
      check("rnd_sync_err",  DW'(sync_err),  DW'(m_se));
      check("rnd_overrun",   DW'(overrun),   DW'(m_ovr));
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
